// File: rtl/gate_access_ctrl_pkg.sv
// Shared types, default parameters and width helpers for the gate access controller.
// The optional PIN-entry timeout is enabled by defining GATE_TIMEOUT_EN.
package gate_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_PIN = 2'd1,
    OPEN     = 2'd2,
    BLOCKED  = 2'd3
  } gate_state_t;

  localparam int unsigned DEF_PIN_WIDTH = 8;
  localparam int unsigned DEF_N_USERS   = 4;
  localparam int unsigned DEF_MAX_TRIES = 3;
  localparam int unsigned DEF_TIMEOUT   = 1024;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (64'(value) > (64'd1 << i)) result = i + 1;
    end
    return result;
  endfunction

  // Index width with a floor of one bit so a single-user table still has a port.
  function automatic int unsigned idx_width(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/gate_access_ctrl_pin_matcher.sv
// Combinational PIN lookup: reports whether pin is in the table and the lowest matching index.
// Part of gate_access_ctrl (GATE_TIMEOUT_EN has no effect here).
module pin_matcher
  import gate_access_ctrl_pkg::*;
#(
  parameter  int unsigned PIN_WIDTH = DEF_PIN_WIDTH,
  parameter  int unsigned N_USERS   = DEF_N_USERS,
  localparam int unsigned ID_W      = idx_width(N_USERS)
) (
  input  logic [PIN_WIDTH-1:0]         pin,
  input  logic [N_USERS*PIN_WIDTH-1:0] pin_table,
  output logic                         hit_c,
  output logic [ID_W-1:0]              idx_c
);

  // Ascending scan; the first hit locks out later entries.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    for (int unsigned i = 0; i < N_USERS; i++) begin
      if (!hit_c && (pin_table[i*PIN_WIDTH +: PIN_WIDTH] == pin)) begin
        hit_c = 1'b1;
        idx_c = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/gate_access_ctrl.sv
// Gate controller merging PIN verification, gate sequencing and tailgate blocking.
// Define GATE_TIMEOUT_EN to abort idle PIN sessions after TIMEOUT cycles.
module gate_access_ctrl
  import gate_access_ctrl_pkg::*;
#(
  parameter  int unsigned PIN_WIDTH = DEF_PIN_WIDTH,
  parameter  int unsigned N_USERS   = DEF_N_USERS,
  parameter  int unsigned MAX_TRIES = DEF_MAX_TRIES,
  parameter  int unsigned TIMEOUT   = DEF_TIMEOUT,
  localparam int unsigned ID_W      = idx_width(N_USERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         arrive_sensor,
  input  logic                         leave_sensor,
  input  logic                         enter,
  input  logic [PIN_WIDTH-1:0]         pin,
  input  logic [N_USERS*PIN_WIDTH-1:0] pin_table,
  output logic                         gate_open,
  output logic                         gate_close,
  output logic                         gate_block,
  output logic                         pin_alarm,
  output logic                         block_alarm,
  output logic [ID_W-1:0]              user_id
);

  localparam int unsigned TRY_W = clog2(MAX_TRIES + 1);

  gate_state_t      state, state_nxt;
  logic [TRY_W-1:0] tries, tries_nxt, tries_inc;
  logic             enter_q, enter_ev;
  logic             hit_c;
  logic [ID_W-1:0]  idx_c;
  logic             pin_alarm_nxt;
  logic [ID_W-1:0]  user_id_nxt;

`ifdef GATE_TIMEOUT_EN
  localparam int unsigned TMR_W = clog2(TIMEOUT + 1);
  logic [TMR_W-1:0] timer, timer_nxt;
`else
  // TIMEOUT is inert without the timer.
  if (TIMEOUT == 0) begin : g_timeout_unused
  end
`endif

  pin_matcher #(
    .PIN_WIDTH (PIN_WIDTH),
    .N_USERS   (N_USERS)
  ) u_pin_matcher (
    .pin       (pin),
    .pin_table (pin_table),
    .hit_c     (hit_c),
    .idx_c     (idx_c)
  );

  assign enter_ev  = enter & ~enter_q;
  assign tries_inc = (tries == TRY_W'(MAX_TRIES)) ? tries : tries + TRY_W'(1);

  // Next-state, attempt accounting and user latch.
  always_comb begin
    state_nxt     = state;
    tries_nxt     = tries;
    pin_alarm_nxt = pin_alarm;
    user_id_nxt   = user_id;
`ifdef GATE_TIMEOUT_EN
    timer_nxt     = '0;
`endif
    unique case (state)
      IDLE: begin
        if (arrive_sensor) begin
          state_nxt = WAIT_PIN;
          tries_nxt = '0;
        end
      end
      WAIT_PIN: begin
        if (enter_ev && hit_c) begin
          state_nxt     = OPEN;
          tries_nxt     = '0;
          pin_alarm_nxt = 1'b0;
          user_id_nxt   = idx_c;
        end else if (enter_ev) begin
          tries_nxt     = tries_inc;
          pin_alarm_nxt = pin_alarm | (tries_inc == TRY_W'(MAX_TRIES));
        end
`ifdef GATE_TIMEOUT_EN
        else if (timer == TMR_W'(TIMEOUT - 1)) begin
          state_nxt = IDLE;
          tries_nxt = '0;
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
`endif
      end
      OPEN: begin
        if (leave_sensor) state_nxt = arrive_sensor ? BLOCKED : IDLE;
      end
      BLOCKED: begin
        if (enter_ev && hit_c) begin
          state_nxt     = IDLE;
          tries_nxt     = '0;
          pin_alarm_nxt = 1'b0;
          user_id_nxt   = idx_c;
        end else if (enter_ev) begin
          tries_nxt     = tries_inc;
          pin_alarm_nxt = pin_alarm | (tries_inc == TRY_W'(MAX_TRIES));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered Moore outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tries       <= '0;
      enter_q     <= 1'b0;
      gate_open   <= 1'b0;
      gate_close  <= 1'b1;
      gate_block  <= 1'b0;
      pin_alarm   <= 1'b0;
      block_alarm <= 1'b0;
      user_id     <= '0;
`ifdef GATE_TIMEOUT_EN
      timer       <= '0;
`endif
    end else begin
      state       <= state_nxt;
      tries       <= tries_nxt;
      enter_q     <= enter;
      gate_open   <= (state_nxt == OPEN);
      gate_close  <= (state_nxt != OPEN);
      gate_block  <= (state_nxt == BLOCKED);
      pin_alarm   <= pin_alarm_nxt;
      block_alarm <= (state_nxt == BLOCKED);
      user_id     <= user_id_nxt;
`ifdef GATE_TIMEOUT_EN
      timer       <= timer_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_gate_access_ctrl.sv
// Bench for gate_access_ctrl: directed scenarios then random traffic against a behavioural model.
// Timeout expectations follow GATE_TIMEOUT_EN.
module tb_gate_access_ctrl;

  localparam int unsigned PW   = 8;
  localparam int unsigned NU   = 2;
  localparam int unsigned MT   = 3;
  localparam int unsigned TOUT = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          arrive_sensor, leave_sensor, enter;
  logic [PW-1:0] pin;
  logic [NU*PW-1:0] pin_table;
  logic          gate_open, gate_close, gate_block, pin_alarm, block_alarm;
  logic [0:0]    user_id;

  int tests = 0;
  int fails = 0;

  gate_access_ctrl #(
    .PIN_WIDTH (PW),
    .N_USERS   (NU),
    .MAX_TRIES (MT),
    .TIMEOUT   (TOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .arrive_sensor (arrive_sensor),
    .leave_sensor  (leave_sensor),
    .enter         (enter),
    .pin           (pin),
    .pin_table     (pin_table),
    .gate_open     (gate_open),
    .gate_close    (gate_close),
    .gate_block    (gate_block),
    .pin_alarm     (pin_alarm),
    .block_alarm   (block_alarm),
    .user_id       (user_id)
  );

  always #5 clk = ~clk;

  // Behavioural model of the access rules.
  typedef enum {M_IDLE, M_WAIT, M_OPEN, M_BLOCK} mode_t;
  mode_t       m_mode;
  int          m_tries, m_idle, m_uid;
  bit          m_alarm, m_prev_enter;
  logic [PW-1:0] tbl [NU];

  function automatic int lookup(input logic [PW-1:0] p);
    for (int k = 0; k < int'(NU); k++) if (tbl[k] == p) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_tries = 0; m_idle = 0; m_uid = 0;
    m_alarm = 0; m_prev_enter = 0;
  endtask

  task automatic wrong_pin();
    if (m_tries < int'(MT)) m_tries++;
    if (m_tries == int'(MT)) m_alarm = 1;
  endtask

  task automatic model_step();
    bit ev;
    int who;
    ev = (enter === 1'b1) && !m_prev_enter;
    m_prev_enter = (enter === 1'b1);
    who = lookup(pin);
    case (m_mode)
      M_IDLE: if (arrive_sensor) begin m_mode = M_WAIT; m_tries = 0; m_idle = 0; end
      M_WAIT: begin
        if (ev && who >= 0) begin
          m_mode = M_OPEN; m_uid = who; m_tries = 0; m_alarm = 0;
        end else if (ev) begin
          wrong_pin();
          m_idle = 0;
        end else begin
`ifdef GATE_TIMEOUT_EN
          m_idle++;
          if (m_idle == int'(TOUT)) begin m_mode = M_IDLE; m_tries = 0; m_idle = 0; end
`endif
        end
      end
      M_OPEN: if (leave_sensor) m_mode = arrive_sensor ? M_BLOCK : M_IDLE;
      M_BLOCK: begin
        if (ev && who >= 0) begin
          m_mode = M_IDLE; m_uid = who; m_tries = 0; m_alarm = 0;
        end else if (ev) wrong_pin();
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".gate_open"},   32'(gate_open),   32'(m_mode == M_OPEN));
    chk({tag, ".gate_close"},  32'(gate_close),  32'(m_mode != M_OPEN));
    chk({tag, ".gate_block"},  32'(gate_block),  32'(m_mode == M_BLOCK));
    chk({tag, ".block_alarm"}, 32'(block_alarm), 32'(m_mode == M_BLOCK));
    chk({tag, ".pin_alarm"},   32'(pin_alarm),   32'(m_alarm));
    chk({tag, ".user_id"},     32'(user_id),     32'(m_uid));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model("step");
  endtask

  task automatic press(input logic [PW-1:0] p);
    pin = p; enter = 1'b1; tick();
    enter = 1'b0; tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pin_table = {8'hC3, 8'h27};
    for (int k = 0; k < int'(NU); k++) tbl[k] = pin_table[k*PW +: PW];
    arrive_sensor = 0; leave_sensor = 0; enter = 0; pin = '0;
    rst = 0;
    #1 rst = 1;
    #1;
    model_reset();
    check_model("reset");
    chk("reset.state", 32'(dut.state), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // Normal entry and exit.
    arrive_sensor = 1; tick();
    pin = 8'hC3; enter = 1; tick();
    chk("normal.open", 32'(gate_open), 32'd1);
    chk("normal.uid",  32'(user_id),   32'd1);
    enter = 0; leave_sensor = 1; arrive_sensor = 0; tick();
    chk("normal.close", 32'(gate_close), 32'd1);
    chk("normal.idle",  32'(dut.state),  32'd0);
    leave_sensor = 0; tick();

    // Wrong attempts: alarm on the third, cleared by a good PIN.
    arrive_sensor = 1; tick(); arrive_sensor = 0;
    press(8'h00); press(8'h00);
    chk("wrong.alarm2", 32'(pin_alarm), 32'd0);
    press(8'h00);
    chk("wrong.alarm3", 32'(pin_alarm), 32'd1);
    press(8'h27);
    chk("wrong.open",   32'(gate_open), 32'd1);
    chk("wrong.clear",  32'(pin_alarm), 32'd0);
    chk("wrong.uid",    32'(user_id),   32'd0);

    // Tailgate from OPEN and PIN recovery.
    arrive_sensor = 1; leave_sensor = 1; tick();
    chk("tail.block",  32'(gate_block),  32'd1);
    chk("tail.balarm", 32'(block_alarm), 32'd1);
    chk("tail.noboth", 32'(gate_open & gate_close), 32'd0);
    arrive_sensor = 0; leave_sensor = 0;
    press(8'h00);
    chk("tail.still", 32'(gate_block), 32'd1);
    press(8'hC3);
    chk("tail.unblock", 32'(gate_block),  32'd0);
    chk("tail.unalarm", 32'(block_alarm), 32'd0);
    chk("tail.idle",    32'(dut.state),   32'd0);

    // Held enter counts once.
    arrive_sensor = 1; tick(); arrive_sensor = 0;
    pin = 8'h00; enter = 1;
    repeat (10) tick();
    chk("held.tries", 32'(dut.tries), 32'd1);
    chk("held.alarm", 32'(pin_alarm), 32'd0);
    enter = 0; tick();
    press(8'h27);
    leave_sensor = 1; tick(); leave_sensor = 0; tick();

    // Idle session: aborts after TIMEOUT cycles only when the timer is built in.
    arrive_sensor = 1; tick(); arrive_sensor = 0;
    repeat (TOUT - 1) tick();
    chk("tout.before", 32'(dut.state), 32'd1);
    tick();
`ifdef GATE_TIMEOUT_EN
    chk("tout.after", 32'(dut.state), 32'd0);
`else
    chk("tout.after", 32'(dut.state), 32'd1);
`endif
    press(8'h27);
    leave_sensor = 1; tick(); leave_sensor = 0; tick();

    // Asynchronous reset in OPEN, between clock edges.
    arrive_sensor = 1; tick(); arrive_sensor = 0;
    press(8'hC3);
    chk("arst.pre", 32'(gate_open), 32'd1);
    #3 rst = 1;
    #1;
    chk("arst.open",  32'(gate_open),  32'd0);
    chk("arst.close", 32'(gate_close), 32'd1);
    chk("arst.state", 32'(dut.state),  32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      arrive_sensor = ($urandom_range(0, 2) == 0);
      leave_sensor  = ($urandom_range(0, 3) == 0);
      enter         = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       pin = 8'hC3;
        1:       pin = 8'h27;
        default: pin = 8'($urandom);
      endcase
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
